ysyx_24090013_wbu: RTL
======================

Name: ysyx_24090013_wbu

Overview:
Write-back unit directly upstream of the integer register file.
- Accepts one retiring instruction at a time from the execute stage via a valid/ready handshake.
- For loads, waits for the data-memory read response and aligns and sign-extends the returned word.
- Drives the register-file write port (wen/waddr/wdata) for exactly one cycle per retired instruction.
- Never issues a write to x0.

Parameters:
XLEN, 32, datapath width for results and memory data.
RA_W, 5, register address width (matches register file waddr).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  execute stage presents an instruction.
in_ready  output  1  WBU can accept; high only in IDLE.
in_rd  input  RA_W  destination register.
in_rd_wen  input  1  instruction writes rd.
in_result  input  XLEN  ALU result (load: effective address).
in_is_load  input  1  instruction is a load.
in_funct3  input  3  load width/sign code.
mem_rvalid  input  1  memory read data valid.
mem_rready  output  1  WBU accepts read data; high only in WAIT_MEM.
mem_rdata  input  XLEN  aligned 32-bit word containing the load target.
rf_wen  output  1  register-file write enable.
rf_waddr  output  RA_W  register-file write address.
rf_wdata  output  XLEN  register-file write data.
retire  output  1  one-cycle pulse per retired instruction.
misalign_err  output  1  one-cycle pulse; only present when the optional feature is compiled in.

Behaviour:
- Reset (async, level): state=IDLE; every registered output and internal latch is 0. That includes rf_wen, rf_waddr, rf_wdata, retire and misalign_err. After rst deasserts, in_ready=1 and mem_rready=0.
- States: IDLE, WAIT_MEM, WRITE. Both in_ready and mem_rready are decoded from state.
- IDLE:
  - On in_valid&in_ready, latch rd, rd_wen, result, funct3 and the addr offset result[1:0].
  - If is_load, go to WAIT_MEM; else go to WRITE with wdata=result.
- WAIT_MEM:
  - On mem_rvalid, latch the aligned load data, then go to WRITE.
  - Stay indefinitely while mem_rvalid=0; there is no timeout.
- WRITE (exactly one cycle):
  - rf_wen = rd_wen & (rd != 0).
  - rf_waddr = latched rd; rf_wdata = latched data.
  - retire=1; then go to IDLE.
- rf_waddr and rf_wdata hold their last values outside WRITE; only rf_wen gates the write.
- Latency:
  - Non-load accepted at cycle N: rf_wen high in cycle N+1, regfile updated at the end of N+1.
  - Load with mem_rvalid at cycle M: write in cycle M+1.
  - Throughput: at most one instruction per 2 cycles (non-load).
- Load align (offset o = addr[1:0]):
  - funct3 000 lb: byte o, sign-extended.
  - funct3 100 lbu: byte o, zero-extended.
  - funct3 001 lh: half at o[1], sign-extended.
  - funct3 101 lhu: half at o[1], zero-extended.
  - funct3 010 lw: full word.
  - Any other funct3: wdata=0, with the write still performed.
- Boundary conditions:
  - mem_rvalid in IDLE or WRITE: ignored and not consumed, since mem_rready=0.
  - in_valid outside IDLE: not accepted; the upstream holds it.
  - Write to x0: retire still pulses; rf_wen stays 0.
  - in_rd_wen=0 load (e.g. suppressed): still waits for the memory response, then retires with no write.
  - rst mid-WAIT_MEM or mid-WRITE: immediate return to IDLE; rf_wen drops asynchronously; the pending instruction is discarded.

Optional Feature:
Macro YSYX_24090013_WBU_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment is checked at latch time: lh/lhu with o[0]=1, or lw with o!=0.
  - A misaligned load still waits for mem_rvalid.
  - In WRITE it asserts misalign_err=1, rf_wen=0, and retire=1.
- Undefined:
  - The misalign_err port does not exist.
  - Offsets are truncated as given in the align rules (lh uses o[1] only; lw ignores o), and the write proceeds.

Decomposition:
- Package ysyx_24090013_pkg contains:
  - the load funct3 constants (LB, LH, LW, LBU, LHU);
  - the WBU state encoding (IDLE=0, WAIT_MEM=1, WRITE=2, 2 bits);
  - the XLEN and RA_W defaults.
- Sub-module ysyx_24090013_load_align: purely combinational (funct3, offset, rdata -> wdata).
  - Reusable by a future store-data/debug path.

Test Plan:
- Non-load: in_valid, rd=5, result=0x1234_5678 at cycle 1 -> cycle 2 shows rf_wen=1, waddr=5, wdata=0x12345678, retire=1; in_ready=0 in cycle 2, 1 in cycle 3.
- lb, addr=0x...2, mem_rdata=0x00_80_FF_11, rvalid 3 cycles after accept -> mem_rready high throughout the wait; wdata=0xFFFF_FF80 one cycle after rvalid. The lbu variant -> 0x0000_0080.
- lh at offset 2, rdata=0x8001_7FFF -> 0xFFFF_8001. lhu at offset 0 -> 0x0000_7FFF. lw -> 0x8001_7FFF.
- rd=0, rd_wen=1 non-load -> retire=1, rf_wen=0. Spurious mem_rvalid=1 in IDLE -> no state change, mem_rready=0.
- rst asserted during WAIT_MEM, then rvalid -> no write, in_ready=1 after release, all outputs 0.
- With YSYX_24090013_WBU_MISALIGN_CHECK_EN: lw at offset 1 -> after rvalid, misalign_err=1, retire=1, rf_wen=0. Without it: the same stimulus writes the full rdata.

Source files
------------

// File: rtl/ysyx_24090013_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24090013_pkg: shared constants and types for the write-back unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ysyx_24090013_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RA_W_DEFAULT = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbu_state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return (((funct3 == LH) || (funct3 == LHU)) && off[0]) || ((funct3 == LW) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24090013_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24090013_load_align: selects and extends load data from a word  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ysyx_24090013_load_align
  import ysyx_24090013_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
  assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wdata_o = '0;
    case (funct3_i)
      LB:      wdata_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     wdata_o = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      wdata_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     wdata_o = {{(XLEN-16){1'b0}}, half_sel};
      LW:      wdata_o = rdata_i;
      default: wdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24090013_wbu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_24090013_wbu: write-back unit driving the register-file port.    |
// | Optional: YSYX_24090013_WBU_MISALIGN_CHECK_EN adds misalign_err.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ysyx_24090013_wbu
  import ysyx_24090013_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_rd_wen,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic            mem_rvalid,
  output logic            mem_rready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wen,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
`ifdef YSYX_24090013_WBU_MISALIGN_CHECK_EN
  output logic            misalign_err,
`endif
  output logic            retire
);

  wbu_state_e      state_q;
  logic [RA_W-1:0] rd_q;
  logic            rd_wen_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            rf_wen_q;
  logic [RA_W-1:0] rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            retire_q;
  logic [XLEN-1:0] load_data;
  logic            load_wen;

  ysyx_24090013_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .rdata_i  (mem_rdata),
    .wdata_o  (load_data)
  );

  assign in_ready   = (state_q == IDLE);
  assign mem_rready = (state_q == WAIT_MEM);

`ifdef YSYX_24090013_WBU_MISALIGN_CHECK_EN
  logic mis_q;
  logic misalign_err_q;
  assign load_wen     = rd_wen_q && (rd_q != '0) && !mis_q;
  assign misalign_err = misalign_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q          <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= 1'b0;
      if (state_q == IDLE && in_valid) begin
        mis_q <= in_is_load && is_misaligned(in_funct3, in_result[1:0]);
      end else if (state_q == WAIT_MEM && mem_rvalid) begin
        misalign_err_q <= mis_q;
      end
    end
  end
`else
  assign load_wen = rd_wen_q && (rd_q != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
    end else begin
      // Write enable and retire are single-cycle pulses owned by WRITE.
      rf_wen_q <= 1'b0;
      retire_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rd_q     <= in_rd;
            rd_wen_q <= in_rd_wen;
            funct3_q <= in_funct3;
            off_q    <= in_result[1:0];
            if (in_is_load) begin
              state_q <= WAIT_MEM;
            end else begin
              state_q    <= WRITE;
              rf_wen_q   <= in_rd_wen && (in_rd != '0);
              rf_waddr_q <= in_rd;
              rf_wdata_q <= in_result;
              retire_q   <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            state_q    <= WRITE;
            rf_wen_q   <= load_wen;
            rf_waddr_q <= rd_q;
            rf_wdata_q <= load_data;
            retire_q   <= 1'b1;
          end
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retire   = retire_q;

endmodule
`default_nettype wire
